// File: rtl/icache_axi_rd_bridge_if.sv
// Bus bundles for the I-cache miss bridge: cache-side request/return and AXI4 read channels.
interface icache_rd_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;

  modport master (output rd_req, rd_type, rd_addr, input rd_rdy, ret_valid, ret_data);
  modport slave  (input rd_req, rd_type, rd_addr, output rd_rdy, ret_valid, ret_data);
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  input arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one I-cache miss (line or uncached word) into one AXI4 read burst and
// returns the collected beats as a 128-bit block with a single-cycle ret_valid.
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic       clk,
  input  logic       resetn,
  icache_rd_if.slave cache,
  axi_rd_if.master   axi
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RET} state_e;

  state_e       state_q, state_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic [1:0]   beat_cnt_q, beat_cnt_d;
  logic [127:0] buf_q, buf_d;
  logic         unused_ok;

  assign unused_ok = ^{axi.rid, axi.rresp, cache.rd_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    buf_d      = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cache.rd_req) begin
          state_d    = S_AR;
          beat_cnt_d = 2'd0;
          if (cache.rd_type == 3'b100) begin
            araddr_d = {cache.rd_addr[31:4], 4'b0};
            arlen_d  = 8'd3;
          end else begin
            araddr_d = {cache.rd_addr[31:2], 2'b0};
            arlen_d  = 8'd0;
          end
        end
      end
      S_AR: begin
        if (axi.arready) state_d = S_R;
      end
      S_R: begin
        if (axi.rvalid) begin
          // The old block stays visible on ret_data until the first new beat,
          // which is where the buffer gets wiped so word reads return zeros above [31:0].
          if (beat_cnt_q == 2'd0) buf_d = {96'b0, axi.rdata};
          else                    buf_d[{beat_cnt_q, 5'b0} +: 32] = axi.rdata;
          if (beat_cnt_q != 2'd3) beat_cnt_d = beat_cnt_q + 2'd1;
          if (axi.rlast)          state_d = S_RET;
        end
      end
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      araddr_q   <= 32'b0;
      arlen_q    <= 8'b0;
      beat_cnt_q <= 2'd0;
      buf_q      <= 128'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      buf_q      <= buf_d;
    end
  end

  // Handshake outputs decode straight from state so an async reset clears them at once.
  assign cache.rd_rdy    = (state_q == S_IDLE);
  assign cache.ret_valid = (state_q == S_RET);
  assign cache.ret_data  = buf_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == S_AR);
  assign axi.rready  = (state_q == S_R);

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: line/word reads, backpressure, gating, reset abort, SLVERR.
module tb_icache_axi_rd_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  icache_rd_if cif();
  axi_rd_if    aif();

  icache_axi_rd_bridge #(.AXI_ID(4'd0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cache  (cif.slave),
    .axi    (aif.master)
  );

  int errs   = 0;
  int checks = 0;
  int ret_pulses = 0;
  int ar_hs      = 0;

  always @(posedge clk) begin
    if (resetn && cif.ret_valid)               ret_pulses <= ret_pulses + 1;
    if (resetn && aif.arvalid && aif.arready)  ar_hs      <= ar_hs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] a);
    cif.rd_req  = 1'b1;
    cif.rd_type = t;
    cif.rd_addr = a;
    step();
    cif.rd_req  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    aif.rvalid = 1'b1;
    aif.rdata  = d;
    aif.rlast  = last;
    step();
    aif.rvalid = 1'b0;
    aif.rlast  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++; if (cif.rd_rdy !== 1'b1) begin errs++; $display("FAIL reset_rd_rdy: got %b want 1", cif.rd_rdy); end
    checks++; if (cif.ret_valid !== 1'b0) begin errs++; $display("FAIL reset_ret_valid: got %b want 0", cif.ret_valid); end
    checks++; if (aif.arvalid !== 1'b0) begin errs++; $display("FAIL reset_arvalid: got %b want 0", aif.arvalid); end
    checks++; if (aif.rready !== 1'b0) begin errs++; $display("FAIL reset_rready: got %b want 0", aif.rready); end
    checks++; if (cif.ret_data !== 128'b0) begin errs++; $display("FAIL reset_ret_data: got %h want 0", cif.ret_data); end
    step(); step();
    resetn = 1'b1;
    step();
    checks++; if (cif.rd_rdy !== 1'b1) begin errs++; $display("FAIL post_reset_rd_rdy: got %b want 1", cif.rd_rdy); end
  endtask

  task automatic test_line();
    int p0;
    aif.arready = 1'b1;
    issue(3'b100, 32'h1FC0_0014);
    checks++; if (aif.arvalid !== 1'b1) begin errs++; $display("FAIL line_arvalid: got %b want 1", aif.arvalid); end
    checks++; if (aif.araddr !== 32'h1FC0_0010) begin errs++; $display("FAIL line_araddr: got %h want 1fc00010", aif.araddr); end
    checks++; if (aif.arlen !== 8'd3) begin errs++; $display("FAIL line_arlen: got %0d want 3", aif.arlen); end
    checks++; if (aif.arsize !== 3'd2 || aif.arburst !== 2'd1 || aif.arid !== 4'd0)
      begin errs++; $display("FAIL line_ar_fixed: got size=%0d burst=%0d id=%0d want 2 1 0", aif.arsize, aif.arburst, aif.arid); end
    checks++; if (cif.rd_rdy !== 1'b0) begin errs++; $display("FAIL line_rd_rdy_busy: got %b want 0", cif.rd_rdy); end
    step();
    checks++; if (aif.rready !== 1'b1 || aif.arvalid !== 1'b0)
      begin errs++; $display("FAIL line_r_state: got rready=%b arvalid=%b want 1 0", aif.rready, aif.arvalid); end
    p0 = ret_pulses;
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b0);
    checks++; if (cif.ret_valid !== 1'b0) begin errs++; $display("FAIL line_early_ret: got %b want 0", cif.ret_valid); end
    beat(32'h44, 1'b1);
    checks++; if (cif.ret_valid !== 1'b1) begin errs++; $display("FAIL line_ret_valid: got %b want 1", cif.ret_valid); end
    checks++; if (cif.ret_data !== 128'h00000044_00000033_00000022_00000011)
      begin errs++; $display("FAIL line_ret_data: got %h want 00000044000000330000002200000011", cif.ret_data); end
    step();
    checks++; if (cif.ret_valid !== 1'b0 || cif.rd_rdy !== 1'b1)
      begin errs++; $display("FAIL line_back_idle: got ret_valid=%b rd_rdy=%b want 0 1", cif.ret_valid, cif.rd_rdy); end
    checks++; if (cif.ret_data !== 128'h00000044_00000033_00000022_00000011)
      begin errs++; $display("FAIL line_ret_hold: got %h", cif.ret_data); end
    checks++; if (ret_pulses - p0 !== 1) begin errs++; $display("FAIL line_pulse_count: got %0d want 1", ret_pulses - p0); end
  endtask

  task automatic test_word();
    issue(3'b010, 32'hBFC0_0007);
    checks++; if (aif.araddr !== 32'hBFC0_0004) begin errs++; $display("FAIL word_araddr: got %h want bfc00004", aif.araddr); end
    checks++; if (aif.arlen !== 8'd0) begin errs++; $display("FAIL word_arlen: got %0d want 0", aif.arlen); end
    step();
    beat(32'hDEADBEEF, 1'b1);
    checks++; if (cif.ret_valid !== 1'b1) begin errs++; $display("FAIL word_ret_valid: got %b want 1", cif.ret_valid); end
    checks++; if (cif.ret_data !== {96'b0, 32'hDEADBEEF})
      begin errs++; $display("FAIL word_ret_data: got %h want upper zero + deadbeef", cif.ret_data); end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] d [4] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    int          g [4] = '{2, 0, 3, 1};
    aif.arready = 1'b0;
    issue(3'b100, 32'h0000_1238);
    cif.rd_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (aif.arvalid !== 1'b1 || aif.araddr !== 32'h0000_1230 || aif.arlen !== 8'd3)
        begin errs++; $display("FAIL bp_ar_stable[%0d]: got v=%b a=%h l=%0d want 1 1230 3", i, aif.arvalid, aif.araddr, aif.arlen); end
      step();
    end
    aif.arready = 1'b1;
    step();
    aif.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < g[i]; k++) begin
        checks++; if (cif.ret_valid !== 1'b0 || aif.rready !== 1'b1)
          begin errs++; $display("FAIL bp_gap[%0d]: got ret_valid=%b rready=%b want 0 1", i, cif.ret_valid, aif.rready); end
        step();
      end
      beat(d[i], i == 3);
    end
    checks++; if (cif.ret_valid !== 1'b1) begin errs++; $display("FAIL bp_ret_valid: got %b want 1", cif.ret_valid); end
    checks++; if (cif.ret_data !== 128'h000000D4_000000C3_000000B2_000000A1)
      begin errs++; $display("FAIL bp_ret_data: got %h want 000000d4000000c3000000b2000000a1", cif.ret_data); end
    step();
  endtask

  task automatic test_back_to_back();
    int h0;
    h0 = ar_hs;
    aif.arready = 1'b1;
    cif.rd_req  = 1'b1;
    cif.rd_type = 3'b100;
    cif.rd_addr = 32'h0000_0040;
    step();
    checks++; if (cif.rd_rdy !== 1'b0) begin errs++; $display("FAIL gate_ar_rdy: got %b want 0", cif.rd_rdy); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cif.rd_rdy !== 1'b0) begin errs++; $display("FAIL gate_r_rdy[%0d]: got %b want 0", i, cif.rd_rdy); end
      beat(32'h100 + i, i == 3);
    end
    checks++; if (cif.ret_valid !== 1'b1 || cif.rd_rdy !== 1'b0)
      begin errs++; $display("FAIL gate_ret: got ret_valid=%b rd_rdy=%b want 1 0", cif.ret_valid, cif.rd_rdy); end
    cif.rd_addr = 32'h0000_0080;
    step();
    checks++; if (cif.rd_rdy !== 1'b1 || cif.ret_valid !== 1'b0)
      begin errs++; $display("FAIL gate_idle: got rd_rdy=%b ret_valid=%b want 1 0", cif.rd_rdy, cif.ret_valid); end
    step();
    cif.rd_req = 1'b0;
    checks++; if (aif.arvalid !== 1'b1 || aif.araddr !== 32'h0000_0080)
      begin errs++; $display("FAIL gate_second_ar: got v=%b a=%h want 1 00000080", aif.arvalid, aif.araddr); end
    step();
    beat(32'h55, 1'b1);
    checks++; if (cif.ret_valid !== 1'b1 || cif.ret_data !== {96'b0, 32'h55})
      begin errs++; $display("FAIL gate_rlast_only: got v=%b d=%h want 1 ...55", cif.ret_valid, cif.ret_data); end
    step();
    checks++; if (ar_hs - h0 !== 2) begin errs++; $display("FAIL gate_ar_count: got %0d want 2", ar_hs - h0); end
  endtask

  task automatic test_reset_mid();
    int p0;
    aif.arready = 1'b1;
    issue(3'b100, 32'h0000_2000);
    step();
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    p0 = ret_pulses;
    resetn = 1'b0;
    #1;
    checks++; if (aif.arvalid !== 1'b0 || aif.rready !== 1'b0 || cif.ret_valid !== 1'b0 || cif.rd_rdy !== 1'b1)
      begin errs++; $display("FAIL rst_mid_clear: got arv=%b rr=%b rv=%b rdy=%b want 0 0 0 1",
                               aif.arvalid, aif.rready, cif.ret_valid, cif.rd_rdy); end
    step(); step();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (ret_pulses - p0 !== 0) begin errs++; $display("FAIL rst_mid_no_pulse: got %0d want 0", ret_pulses - p0); end
    issue(3'b100, 32'h0000_3004);
    checks++; if (aif.araddr !== 32'h0000_3000) begin errs++; $display("FAIL rst_mid_araddr: got %h want 00003000", aif.araddr); end
    step();
    for (int i = 0; i < 4; i++) beat(32'h900 + i, i == 3);
    checks++; if (cif.ret_valid !== 1'b1 || cif.ret_data !== 128'h00000903_00000902_00000901_00000900)
      begin errs++; $display("FAIL rst_mid_after: got v=%b d=%h", cif.ret_valid, cif.ret_data); end
    step();
  endtask

  task automatic test_slverr();
    int p0;
    aif.rresp   = 2'b10;
    aif.arready = 1'b1;
    p0 = ret_pulses;
    issue(3'b100, 32'h0000_5000);
    step();
    for (int i = 0; i < 4; i++) beat(32'hE0 + i, i == 3);
    checks++; if (cif.ret_valid !== 1'b1 || cif.ret_data !== 128'h000000E3_000000E2_000000E1_000000E0)
      begin errs++; $display("FAIL slverr_data: got v=%b d=%h", cif.ret_valid, cif.ret_data); end
    step();
    checks++; if (cif.rd_rdy !== 1'b1 || cif.ret_valid !== 1'b0)
      begin errs++; $display("FAIL slverr_idle: got rdy=%b rv=%b want 1 0", cif.rd_rdy, cif.ret_valid); end
    checks++; if (ret_pulses - p0 !== 1) begin errs++; $display("FAIL slverr_pulses: got %0d want 1", ret_pulses - p0); end
    aif.rresp = 2'b00;
  endtask

  initial begin
    cif.rd_req  = 1'b0;
    cif.rd_type = 3'b000;
    cif.rd_addr = 32'b0;
    aif.arready = 1'b0;
    aif.rid     = 4'd0;
    aif.rdata   = 32'b0;
    aif.rresp   = 2'b00;
    aif.rlast   = 1'b0;
    aif.rvalid  = 1'b0;
    test_reset();
    test_line();
    test_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_slverr();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
